pc_predict: RTL and testbench

Fetch-side PC generator and tournament branch predictor, producing the `if_pc`, `pre_take_or_not` and `pre_sel` values consumed by the IF/ID pipeline register. Each cycle it proposes the next fetch PC from the instruction currently returned by instruction memory. Resolved branches reported by EX train three 2-bit counter tables and a global history register. EX redirects override everything.

---
 rtl/pc_predict_pkg.sv | 26 ++
 rtl/pc_predict_table.sv | 49 ++++
 rtl/pc_predict.sv | 178 +++++++++++++++++
 tb/tb_pc_predict.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_predict_pkg.sv
// Shared definitions for the fetch PC generator and tournament predictor:
// opcodes decoded at fetch, the 2-bit counter type and its update rule.
package pc_predict_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef logic [1:0] cnt_t;

  // Weak not-taken for direction tables, weak bimodal for the chooser.
  localparam cnt_t CNT_INIT = 2'b01;

  // Saturating 2-bit counter step toward 'up' (inc stops at 3, dec at 0).
  function automatic cnt_t sat_update(input cnt_t cnt, input logic up);
    cnt_t res;
    if (up) begin
      if (cnt == 2'b11) res = cnt;
      else              res = cnt + 2'b01;
    end else begin
      if (cnt == 2'b00) res = cnt;
      else              res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_predict_table.sv
// pred_table: 2^IDX_W x 2-bit counter array with a combinational fetch read
// port, a combinational training read port and one synchronous write port.
// A write is seen by the read ports only from the following cycle.
module pred_table
  import pc_predict_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output cnt_t             rd_data,
  input  logic [IDX_W-1:0] tr_idx,
  output cnt_t             tr_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  cnt_t             wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  cnt_t mem_q [DEPTH];
  cnt_t mem_d [DEPTH];

  assign rd_data = mem_q[rd_idx];
  assign tr_data = mem_q[tr_idx];

  // Next table contents: apply the single training write, if any.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_idx] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Counter storage; every entry returns to CNT_INIT on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CNT_INIT;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_predict.sv
// pc_predict: fetch PC generator with a bimodal/gshare tournament predictor.
// Optional feature macro: PC_PREDICT_PERF_EN adds branch and mispredict
// counters (br_cnt_o, mispred_cnt_o).
module pc_predict
  import pc_predict_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_W    = 6,
  parameter int          GHR_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [31:0] if_inst,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_br_pc,
  input  logic        ex_br_taken,
  input  logic        ex_pre_take,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic        pre_take_or_not_o,
  output logic        pre_sel_o
`ifdef PC_PREDICT_PERF_EN
  ,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);

  logic [31:0]      pc_q, pc_d;
  logic             ce_q, ce_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic [IDX_W-1:0] f_bi_s, f_gi_s, t_bi_s, t_gi_s;
  cnt_t             bim_rd_s, gsh_rd_s, cho_rd_s;
  cnt_t             bim_tr_s, gsh_tr_s, cho_tr_s;
  cnt_t             bim_wr_s, gsh_wr_s, cho_wr_s;
  logic             cho_we_s, bim_ok_s, gsh_ok_s;
  logic             take_s, sel_s;
  logic [31:0]      target_s, b_imm_s, j_imm_s, pc_inc_s;

  // Fetch uses the live GHR; training recomputes with the GHR of its own cycle.
  assign f_bi_s = pc_q[IDX_W+1:2];
  assign f_gi_s = f_bi_s ^ IDX_W'(ghr_q);
  assign t_bi_s = ex_br_pc[IDX_W+1:2];
  assign t_gi_s = t_bi_s ^ IDX_W'(ghr_q);

  pred_table #(.IDX_W(IDX_W)) u_bim (
    .clk(clk), .rst(rst), .rd_idx(f_bi_s), .rd_data(bim_rd_s),
    .tr_idx(t_bi_s), .tr_data(bim_tr_s),
    .we(ex_br_valid), .wr_idx(t_bi_s), .wr_data(bim_wr_s)
  );

  pred_table #(.IDX_W(IDX_W)) u_gsh (
    .clk(clk), .rst(rst), .rd_idx(f_gi_s), .rd_data(gsh_rd_s),
    .tr_idx(t_gi_s), .tr_data(gsh_tr_s),
    .we(ex_br_valid), .wr_idx(t_gi_s), .wr_data(gsh_wr_s)
  );

  pred_table #(.IDX_W(IDX_W)) u_cho (
    .clk(clk), .rst(rst), .rd_idx(f_bi_s), .rd_data(cho_rd_s),
    .tr_idx(t_bi_s), .tr_data(cho_tr_s),
    .we(cho_we_s), .wr_idx(t_bi_s), .wr_data(cho_wr_s)
  );

  assign b_imm_s  = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                     if_inst[30:25], if_inst[11:8], 1'b0};
  assign j_imm_s  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                     if_inst[20], if_inst[30:21], 1'b0};
  assign pc_inc_s = pc_q + 32'd4;

  // Decode the fetched instruction and form prediction and target.
  always_comb begin
    take_s   = 1'b0;
    sel_s    = 1'b0;
    target_s = pc_inc_s;
    case (if_inst[6:0])
      OPC_BRANCH: begin
        sel_s    = cho_rd_s[1];
        target_s = pc_q + b_imm_s;
        if (cho_rd_s[1]) take_s = gsh_rd_s[1];
        else             take_s = bim_rd_s[1];
      end
      OPC_JAL: begin
        take_s   = 1'b1;
        target_s = pc_q + j_imm_s;
      end
      default: begin
        take_s   = 1'b0;
        sel_s    = 1'b0;
        target_s = pc_inc_s;
      end
    endcase
  end

  // Next fetch PC: redirect beats stall beats prediction; frozen until ce is up.
  always_comb begin
    ce_d = 1'b1;
    pc_d = pc_q;
    if (!ce_q)              pc_d = pc_q;
    else if (ex_redirect)   pc_d = ex_redirect_pc;
    else if (stall[0])      pc_d = pc_q;
    else if (take_s)        pc_d = target_s;
    else                    pc_d = pc_inc_s;
  end

  // Training: both direction tables learn the outcome; chooser only on disagreement.
  always_comb begin
    bim_wr_s = sat_update(bim_tr_s, ex_br_taken);
    gsh_wr_s = sat_update(gsh_tr_s, ex_br_taken);
    bim_ok_s = (bim_tr_s[1] == ex_br_taken);
    gsh_ok_s = (gsh_tr_s[1] == ex_br_taken);
    cho_wr_s = sat_update(cho_tr_s, gsh_ok_s);
    cho_we_s = ex_br_valid & (bim_ok_s != gsh_ok_s);
    if (ex_br_valid) ghr_d = {ghr_q[GHR_W-2:0], ex_br_taken};
    else             ghr_d = ghr_q;
  end

  // PC, chip enable and global history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ce_q  <= 1'b0;
      ghr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ce_q  <= ce_d;
      ghr_q <= ghr_d;
    end
  end

  assign pc_o              = pc_q;
  assign ce_o              = ce_q;
  assign pre_take_or_not_o = take_s & rst;
  assign pre_sel_o         = sel_s & rst;

`ifdef PC_PREDICT_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  // Count resolved branches and those whose carried prediction was wrong.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (ex_br_valid) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (ex_pre_take != ex_br_taken) mis_cnt_d = mis_cnt_q + 32'd1;
      else                            mis_cnt_d = mis_cnt_q;
    end else begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Performance counter registers, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mis_cnt_q;

  logic unused_bits_s;
  assign unused_bits_s = ^{stall[5:1], ex_br_pc[31:IDX_W+2], ex_br_pc[1:0]};
`else
  logic unused_bits_s;
  assign unused_bits_s = ^{stall[5:1], ex_br_pc[31:IDX_W+2], ex_br_pc[1:0],
                           ex_pre_take};
`endif

endmodule

// File: tb/tb_pc_predict.sv
// Scoreboard bench for pc_predict: stimulus pushes the expected fetch state
// for each cycle, a negedge monitor pops and compares.
module tb_pc_predict;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BR16  = 32'h0000_0863;  // BEQ, imm = +16
  localparam logic [31:0] JAL8  = 32'h0080_006F;  // JAL, imm = +8
  localparam logic [31:0] JALR0 = 32'h0000_8067;  // JALR (ret)

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [31:0] if_inst;
  logic        ex_br_valid, ex_br_taken, ex_pre_take, ex_redirect;
  logic [31:0] ex_br_pc, ex_redirect_pc;
  logic [31:0] pc_o;
  logic        ce_o, pre_take_or_not_o, pre_sel_o;
`ifdef PC_PREDICT_PERF_EN
  logic [31:0] br_cnt_o, mispred_cnt_o;
`endif

  always #5 clk = ~clk;

  pc_predict #(.RESET_PC(32'h0000_0100), .IDX_W(6), .GHR_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_inst(if_inst),
    .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
    .ex_pre_take(ex_pre_take), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .pc_o(pc_o), .ce_o(ce_o),
    .pre_take_or_not_o(pre_take_or_not_o), .pre_sel_o(pre_sel_o)
`ifdef PC_PREDICT_PERF_EN
    , .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        take;
    logic        sel;
    logic        chk_pred;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tag_cnt  = 0;

  task automatic check(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, req);
  endtask

  // Monitor: one expected record per presented cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_o", e.tag, pc_o, e.pc);
      check("ce_o", e.tag, {31'd0, ce_o}, {31'd0, e.ce});
      if (e.chk_pred) begin
        check("pre_take", e.tag, {31'd0, pre_take_or_not_o}, {31'd0, e.take});
        check("pre_sel", e.tag, {31'd0, pre_sel_o}, {31'd0, e.sel});
      end
    end
  end

  task automatic expect_o(input logic [31:0] pc, input logic ce,
                          input logic take, input logic sel, input logic chk);
    exp_t e;
    e.pc = pc; e.ce = ce; e.take = take; e.sel = sel; e.chk_pred = chk;
    e.tag = tag_cnt;
    tag_cnt++;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_br_valid = 1'b0;
    ex_redirect = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic pre);
    ex_br_valid = 1'b1;
    ex_br_pc    = pc;
    ex_br_taken = taken;
    ex_pre_take = pre;
  endtask

  task automatic redirect(input logic [31:0] pc);
    ex_redirect    = 1'b1;
    ex_redirect_pc = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b0; stall = 6'd0; if_inst = JAL8;
    ex_br_valid = 1'b0; ex_br_pc = 32'd0; ex_br_taken = 1'b0; ex_pre_take = 1'b0;
    ex_redirect = 1'b0; ex_redirect_pc = 32'd0;

    // In reset: JAL fetched but prediction outputs forced low.
    #2 expect_o(32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    #10 rst = 1'b1; if_inst = NOP;

    // Sequential NOP fetch after release.
    tick; expect_o(32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; expect_o(32'h104, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; expect_o(32'h108, 1'b1, 1'b0, 1'b0, 1'b1);

    // Redirect wins over stall, then stall alone holds.
    stall = 6'b000001; redirect(32'h400);
    tick; expect_o(32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; expect_o(32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; expect_o(32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
    stall = 6'd0; redirect(32'h200);

    // Branch at 0x200, counters at reset: not taken.
    tick; if_inst = BR16; expect_o(32'h200, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; if_inst = NOP;  expect_o(32'h204, 1'b1, 1'b0, 1'b0, 1'b1);
    train(32'h200, 1'b1, 1'b0);
    tick; expect_o(32'h208, 1'b1, 1'b0, 1'b0, 1'b1);
    train(32'h200, 1'b1, 1'b0);
    tick; expect_o(32'h20C, 1'b1, 1'b0, 1'b0, 1'b1);
    redirect(32'h200);
    // Bimodal now strongly taken.
    tick; if_inst = BR16; expect_o(32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
    tick; if_inst = NOP;  expect_o(32'h210, 1'b1, 1'b0, 1'b0, 1'b1);

    // JAL wrapping past 2^32, then JALR falls through.
    redirect(32'hFFFF_FFFC);
    tick; if_inst = JAL8;  expect_o(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b1);
    tick; if_inst = JALR0; expect_o(32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; if_inst = NOP;   expect_o(32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b1);

    // Alternating branch at 0x380 while fetch is stalled on it.
    stall = 6'b000001; redirect(32'h380);
    tick; if_inst = BR16; expect_o(32'h380, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      train(32'h380, (i % 2) == 0, 1'b0);
      tick;
      expect_o(32'h380, 1'b1, 1'b1, 1'b1, i == 19);
    end
    // Next outcome is N: gshare must say not-taken while bimodal says taken.
    train(32'h380, 1'b1, 1'b0);
    tick; expect_o(32'h380, 1'b1, 1'b0, 1'b1, 1'b1);
    stall = 6'd0;
    tick; if_inst = NOP; expect_o(32'h384, 1'b1, 1'b0, 1'b0, 1'b1);

    // Async reset with a redirect pending: redirect is discarded, tables cleared.
    tick; redirect(32'h500); rst = 1'b0;
    #1 expect_o(32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    tick; expect_o(32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    tick; if_inst = BR16; expect_o(32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; if_inst = NOP;  expect_o(32'h104, 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef PC_PREDICT_PERF_EN
    begin
      logic [4:0] tk;
      logic [4:0] pk;
      tk = 5'b00111;
      pk = 5'b10101;
      for (int k = 0; k < 5; k++) begin
        train(32'h600, tk[k], pk[k]);
        tick;
      end
      check("br_cnt", -1, br_cnt_o, 32'd5);
      check("mispred_cnt", -1, mispred_cnt_o, 32'd2);
      rst = 1'b0;
      #1;
      check("br_cnt_rst", -1, br_cnt_o, 32'd0);
      check("mispred_cnt_rst", -1, mispred_cnt_o, 32'd0);
      rst = 1'b1;
    end
`endif

    tick;
    tick;
    check("sb_drain", -1, exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
